hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// Parametrised successor to the fixed EX/MEM/WB stall/flush and forward logic of the 5-stage core.
// Tracks in-flight destination registers across DEPTH post-decode stages and classifies each one
// (ALU/LOAD/MULDIV). Generates fetch/decode/EX enables, flushes and registered forward selects.
// Stalls EX for variable-latency mul/div and keeps stall/flush performance counters.
// PARAMETERS
// DEPTH       3   tracked stages after decode: pos1=EX, pos2=MEM, ..., posDEPTH=WB (>=2)
// REG_AW      5   register address width
// LOAD_READY  3   first position from which a load result is forwardable (2..DEPTH)
// CNT_W       32  perf counter width
// FWD_W       $clog2(DEPTH+1), derived localparam; forward select width
// PORTS
// clk         in   1      clock
// rst         in   1      reset; synchronous, active-low
// id_valid    in   1      valid instruction in decode
// id_rs1      in   REG_AW decode source 1
// id_rs1_need in   1      rs1 is read
// id_rs2      in   REG_AW decode source 2
// id_rs2_need in   1      rs2 is read
// id_rd       in   REG_AW decode destination
// id_we       in   1      decode writes rd
// id_cls      in   2      0=ALU, 1=LOAD, 2=MULDIV, 3=reserved (treated as ALU)
// ex_taken    in   1      branch/jump redirect resolved in EX
// md_busy     in   1      multi-cycle op in EX not finished
// if_en       out  1      PC/fetch advance
// de_en       out  1      IF/DE register load
// ex_en       out  1      DE/EX register load
// de_flush    out  1      clear IF/DE register
// ex_flush    out  1      insert bubble into DE/EX register
// fwd1_sel    out  FWD_W  0=regfile, k=forward from position k (registered, valid with EX)
// fwd2_sel    out  FWD_W  as fwd1_sel for rs2
// stall_cnt   out  CNT_W  decode stall cycles, saturating
// flush_cnt   out  CNT_W  taken-redirect cycles, saturating
// BEHAVIOUR
// - Reset (rst==0 at posedge): all entries invalid, fwd sels 0, counters 0.
// - Reset outputs: if_en=de_en=ex_en=0, de_flush=ex_flush=1 while rst==0.
// - Entry per position: valid, rd, cls. rd==0 or id_we==0 enters as invalid (never hazards).
// - Hazard check at decode (combinational):
//   - For each needed rs!=0, pick the youngest valid entry at position p with rd==rs; q=p+1.
//   - ready_pos: ALU=2, MULDIV=2, LOAD=LOAD_READY. Stall if q<ready_pos, else sel=q.
//   - No match, or q>DEPTH: sel=0 (regfile is write-before-read).
//   - stall_d = id_valid & hazard & !ex_taken.
// - hold = md_busy: if_en=de_en=ex_en=0, ex_flush=0, and pos1 holds.
//   - During hold, pos2 <= bubble, pos k <= pos k-1 for k>=3, and decode hazards are re-evaluated each cycle.
// - No hold:
//   - Positions shift (pos k <= pos k-1).
//   - pos1 <= decode entry if id_valid & !stall_d & !ex_taken, else bubble.
// - ex_taken (no hold): if_en=de_en=ex_en=1, de_flush=ex_flush=1, flush_cnt+1. Overrides stall_d in the same cycle.
// - stall_d (no hold): if_en=de_en=0, ex_en=1, ex_flush=1, stall_cnt+1.
// - Otherwise: enables 1, flushes 0.
// - fwd sels are registered when the DE/EX register loads a real instruction; they go to 0 on a bubble and hold during hold.
// - MULDIV latches its operands in its first EX cycle; fwd sels are not re-tracked while held.
// - ex_taken together with md_busy is illegal (bench assertion); hold wins.
// - Counters saturate at all-ones; hold cycles are not counted as stalls.
// TESTING
// 1. ALU x5 then consumer rs1=5 -> no stall; next cycle fwd1_sel=2, stall_cnt=0.
// 2. LOAD x6 then consumer rs2=6, LOAD_READY=3 -> 1 stall: if_en=0, ex_flush=1; then fwd2_sel=3, stall_cnt=1.
// 3. Load-use hazard and ex_taken in the same cycle -> de_flush=ex_flush=1, if_en=1, stall_cnt unchanged, flush_cnt=1.
// 4. MULDIV x7 with md_busy high 4 cycles:
//    -> if_en/de_en/ex_en low 4 cycles, MEM gets 4 bubbles;
//    -> dependent rs1=7 then issues with fwd1_sel=2.
// 5. Two writers of x9 in flight and consumer rd==0 -> youngest selected (sel=2, not 3); rd=0 writer causes no stall.
// 6. rst low 1 cycle during a hold with counters nonzero -> entries cleared, sels=0, counters 0, enables 1 after release.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the in-order core.
// Tracks destination registers in flight across DEPTH post-decode positions
// (pos1=EX ... posDEPTH=WB), decides decode stalls, front-end flushes and the
// registered operand-forward selects, and counts stall and redirect cycles.
module hazard_scoreboard #(
   parameter int  DEPTH      = 3,
   parameter int  REG_AW     = 5,
   parameter int  LOAD_READY = 3,
   parameter int  CNT_W      = 32,
   localparam int FWD_W      = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs1_need,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs2_need,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_we,
   input  logic [1:0]        id_cls,
   input  logic              ex_taken,
   input  logic              md_busy,
   output logic              if_en,
   output logic              de_en,
   output logic              ex_en,
   output logic              de_flush,
   output logic              ex_flush,
   output logic [FWD_W-1:0]  fwd1_sel,
   output logic [FWD_W-1:0]  fwd2_sel,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] CLS_LOAD = 2'd1;

   logic              valid_q [DEPTH];
   logic              valid_d [DEPTH];
   logic [REG_AW-1:0] rd_q    [DEPTH];
   logic [REG_AW-1:0] rd_d    [DEPTH];
   logic [1:0]        cls_q   [DEPTH];
   logic [1:0]        cls_d   [DEPTH];
   logic [FWD_W-1:0]  fwd1_q, fwd1_d;
   logic [FWD_W-1:0]  fwd2_q, fwd2_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              hazard;
   logic              id_stall;
   logic              hold;
   logic              issue;
   logic [FWD_W-1:0]  src_sel [2];
   logic              src_haz [2];

   assign hold     = md_busy;
   assign id_stall = id_valid & hazard & ~ex_taken;
   assign issue    = ~hold & id_valid & ~id_stall & ~ex_taken;

   // Per-source lookup: youngest matching producer decides stall or forward position.
   always_comb begin : hazard_comb
      logic [REG_AW-1:0] rs;
      logic              need;
      logic              found;
      logic [1:0]        mcls;
      int                mq;
      int                ready;
      rs    = '0;
      need  = 1'b0;
      found = 1'b0;
      mcls  = '0;
      mq    = 0;
      ready = 2;
      for (int s = 0; s < 2; s++) begin
         rs    = (s == 0) ? id_rs1 : id_rs2;
         need  = (s == 0) ? id_rs1_need : id_rs2_need;
         found = 1'b0;
         mcls  = '0;
         mq    = 0;
         ready = 2;
         // Walk oldest to youngest so the youngest match is the one kept.
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (need && (rs != '0) && valid_q[k] && (rd_q[k] == rs)) begin
               found = 1'b1;
               mcls  = cls_q[k];
               mq    = k + 2;
            end
         end
         src_sel[s] = '0;
         src_haz[s] = 1'b0;
         // A producer leaving WB this cycle is already visible in the regfile.
         if (found && (mq <= DEPTH)) begin
            ready = (mcls == CLS_LOAD) ? LOAD_READY : 2;
            if (mq < ready) src_haz[s] = 1'b1;
            else            src_sel[s] = FWD_W'(mq);
         end
      end
      hazard = src_haz[0] | src_haz[1];
   end

   // Next state of the tracked positions; during a hold EX keeps its op and MEM takes a bubble.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         valid_d[k] = valid_q[k];
         rd_d[k]    = rd_q[k];
         cls_d[k]   = cls_q[k];
      end
      if (hold) begin
         valid_d[1] = 1'b0;
         rd_d[1]    = '0;
         cls_d[1]   = '0;
         for (int k = 2; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
            cls_d[k]   = cls_q[k-1];
         end
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
            cls_d[k]   = cls_q[k-1];
         end
         valid_d[0] = issue & id_we & (id_rd != '0);
         rd_d[0]    = id_rd;
         cls_d[0]   = id_cls;
      end
   end

   // Forward selects follow what enters EX; saturating stall/redirect counters.
   always_comb begin
      fwd1_d      = fwd1_q;
      fwd2_d      = fwd2_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!hold) begin
         fwd1_d = issue ? src_sel[0] : '0;
         fwd2_d = issue ? src_sel[1] : '0;
         if (ex_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
         if (id_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Pipeline enables and flushes; reset forces the front end closed and flushed.
   always_comb begin
      if_en    = 1'b1;
      de_en    = 1'b1;
      ex_en    = 1'b1;
      de_flush = 1'b0;
      ex_flush = 1'b0;
      if (!rst) begin
         if_en    = 1'b0;
         de_en    = 1'b0;
         ex_en    = 1'b0;
         de_flush = 1'b1;
         ex_flush = 1'b1;
      end else if (hold) begin
         if_en = 1'b0;
         de_en = 1'b0;
         ex_en = 1'b0;
      end else if (ex_taken) begin
         de_flush = 1'b1;
         ex_flush = 1'b1;
      end else if (id_stall) begin
         if_en    = 1'b0;
         de_en    = 1'b0;
         ex_flush = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k] <= 1'b0;
            rd_q[k]    <= '0;
            cls_q[k]   <= '0;
         end
         fwd1_q      <= '0;
         fwd2_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_q[k] <= valid_d[k];
            rd_q[k]    <= rd_d[k];
            cls_q[k]   <= cls_d[k];
         end
         fwd1_q      <= fwd1_d;
         fwd2_q      <= fwd2_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd1_sel  = fwd1_q;
   assign fwd2_sel  = fwd2_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, LOAD_READY=3, 2-bit counters
// so that saturation is reachable).
module tb_hazard_scoreboard;

   localparam int DEPTH = 3;
   localparam int AW    = 5;
   localparam int CW    = 2;
   localparam int FW    = $clog2(DEPTH + 1);

   localparam logic [1:0] ALU = 2'd0;
   localparam logic [1:0] LD  = 2'd1;
   localparam logic [1:0] MD  = 2'd2;

   logic          clk;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs1;
   logic          id_rs1_need;
   logic [AW-1:0] id_rs2;
   logic          id_rs2_need;
   logic [AW-1:0] id_rd;
   logic          id_we;
   logic [1:0]    id_cls;
   logic          ex_taken;
   logic          md_busy;
   logic          if_en, de_en, ex_en, de_flush, ex_flush;
   logic [FW-1:0] fwd1_sel, fwd2_sel;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_run  = 0;
   int n_fail = 0;

   hazard_scoreboard #(
      .DEPTH(DEPTH), .REG_AW(AW), .LOAD_READY(3), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_need(id_rs1_need),
      .id_rs2(id_rs2), .id_rs2_need(id_rs2_need), .id_rd(id_rd), .id_we(id_we),
      .id_cls(id_cls), .ex_taken(ex_taken), .md_busy(md_busy),
      .if_en(if_en), .de_en(de_en), .ex_en(ex_en), .de_flush(de_flush), .ex_flush(ex_flush),
      .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) assert (!(ex_taken && md_busy)) else $error("ex_taken with md_busy");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] r1, input logic n1,
                        input logic [AW-1:0] r2, input logic n2,
                        input logic [AW-1:0] rd, input logic we, input logic [1:0] cls);
      @(negedge clk);
      id_valid    = v;
      id_rs1      = r1;
      id_rs1_need = n1;
      id_rs2      = r2;
      id_rs2_need = n2;
      id_rd       = rd;
      id_we       = we;
      id_cls      = cls;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU);
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; ex_taken = 1'b0; md_busy = 1'b0;
      id_valid = 1'b0; id_rs1 = '0; id_rs1_need = 1'b0; id_rs2 = '0; id_rs2_need = 1'b0;
      id_rd = '0; id_we = 1'b0; id_cls = ALU;

      // reset
      #1;
      chk("rst_if_en", if_en, 0);
      chk("rst_ex_en", ex_en, 0);
      chk("rst_de_flush", de_flush, 1);
      chk("rst_ex_flush", ex_flush, 1);
      tick();
      chk("rst_fwd1", fwd1_sel, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);

      // 1: ALU x5 -> consumer rs1=5 forwards from MEM without stall
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, ALU);
      rst = 1'b1;
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, ALU);
      #1;
      chk("t1_if_en", if_en, 1);
      chk("t1_ex_flush", ex_flush, 0);
      tick();
      chk("t1_fwd1", fwd1_sel, 2);
      chk("t1_stall_cnt", stall_cnt, 0);
      idle(1);
      chk("t1_bubble_fwd1", fwd1_sel, 0);
      idle(2);

      // 2: load-use on rs2 -> one stall, then forward from WB
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, LD);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd11, 1'b1, ALU);
      #1;
      chk("t2_stall_if_en", if_en, 0);
      chk("t2_stall_de_en", de_en, 0);
      chk("t2_stall_ex_en", ex_en, 1);
      chk("t2_stall_ex_flush", ex_flush, 1);
      tick();
      chk("t2_stall_cnt", stall_cnt, 1);
      chk("t2_release_if_en", if_en, 1);
      chk("t2_release_ex_flush", ex_flush, 0);
      tick();
      chk("t2_fwd2", fwd2_sel, 3);
      chk("t2_stall_cnt_after", stall_cnt, 1);
      idle(3);

      // producer already in WB -> regfile, no stall even for a load
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, LD);
      tick();
      idle(2);
      drive(1'b1, 5'd22, 1'b1, 5'd0, 1'b0, 5'd23, 1'b1, ALU);
      #1;
      chk("wb_if_en", if_en, 1);
      tick();
      chk("wb_fwd1", fwd1_sel, 0);
      idle(3);

      // 3: load-use and redirect together -> redirect wins
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LD);
      tick();
      drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, ALU);
      ex_taken = 1'b1;
      #1;
      chk("t3_de_flush", de_flush, 1);
      chk("t3_ex_flush", ex_flush, 1);
      chk("t3_if_en", if_en, 1);
      chk("t3_de_en", de_en, 1);
      tick();
      chk("t3_stall_cnt", stall_cnt, 1);
      chk("t3_flush_cnt", flush_cnt, 1);
      chk("t3_fwd1", fwd1_sel, 0);
      // redirect held three more cycles: 2-bit counter saturates at 3
      tick();
      tick();
      tick();
      chk("sat_flush_cnt", flush_cnt, 3);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU);
      ex_taken = 1'b0;
      tick();
      idle(3);

      // 4: MULDIV x7 held 4 cycles; ALU x14 behind it is bubbled out of MEM
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, ALU);
      tick();
      drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, MD);
      #1;
      chk("t4_md_issue_if_en", if_en, 1);
      tick();
      chk("t4_md_fwd1", fwd1_sel, 2);
      chk("t4_md_fwd2", fwd2_sel, 0);
      drive(1'b1, 5'd7, 1'b1, 5'd14, 1'b1, 5'd15, 1'b1, ALU);
      md_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_hold_if_en", if_en, 0);
         chk("t4_hold_de_en", de_en, 0);
         chk("t4_hold_ex_en", ex_en, 0);
         chk("t4_hold_ex_flush", ex_flush, 0);
         tick();
         chk("t4_hold_fwd1", fwd1_sel, 2);
         chk("t4_hold_fwd2", fwd2_sel, 0);
         @(negedge clk);
      end
      md_busy = 1'b0;
      #1;
      chk("t4_release_if_en", if_en, 1);
      chk("t4_release_ex_flush", ex_flush, 0);
      tick();
      chk("t4_dep_fwd1", fwd1_sel, 2);
      chk("t4_dep_fwd2", fwd2_sel, 0);
      chk("t4_stall_cnt", stall_cnt, 1);
      idle(3);

      // 5: two writers of x9, youngest wins; rd=0 / we=0 writers never hazard
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, ALU);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, ALU);
      tick();
      drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, LD);
      #1;
      chk("t5_if_en", if_en, 1);
      tick();
      chk("t5_fwd1_youngest", fwd1_sel, 2);
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd21, 1'b1, ALU);
      #1;
      chk("t5_rd0_if_en", if_en, 1);
      tick();
      chk("t5_rd0_fwd1", fwd1_sel, 0);
      chk("t5_rd0_fwd2", fwd2_sel, 0);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b0, LD);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 5'd24, 1'b1, ALU);
      #1;
      chk("t5_we0_if_en", if_en, 1);
      tick();
      chk("t5_we0_fwd2", fwd2_sel, 0);
      chk("t5_stall_cnt", stall_cnt, 1);
      idle(3);

      // 6: reset pulse during a hold clears everything
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, ALU);
      tick();
      drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, MD);
      tick();
      chk("t6_pre_fwd1", fwd1_sel, 2);
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, ALU);
      md_busy = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_rst_if_en", if_en, 0);
      chk("t6_rst_de_flush", de_flush, 1);
      chk("t6_rst_ex_flush", ex_flush, 1);
      tick();
      chk("t6_fwd1", fwd1_sel, 0);
      chk("t6_stall_cnt", stall_cnt, 0);
      chk("t6_flush_cnt", flush_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      md_busy = 1'b0;
      #1;
      chk("t6_if_en", if_en, 1);
      chk("t6_de_en", de_en, 1);
      chk("t6_ex_en", ex_en, 1);
      chk("t6_ex_flush", ex_flush, 0);
      tick();
      chk("t6_after_fwd1", fwd1_sel, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
